// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: POR plus per-source requests select channels, hold them in reset,
// then release them in ascending order with a fixed stagger. Outputs drive downstream async resets.
module reset_sequencer #(
  parameter int unsigned Channel_Count  = 4,
  parameter int unsigned Source_Count   = 2,
  parameter int unsigned Delay_Cycles   = 1024,
  parameter int unsigned Assert_Cycles  = 8,
  parameter int unsigned Stagger_Cycles = 16,
  parameter int unsigned Sync_Stages    = 2,
  parameter int unsigned Buffer_Stages  = 4
) (
  input  logic                                    clk,
  input  logic                                    async_rst_n,
  input  logic [Source_Count-1:0]                 rst_req,
  input  logic [Source_Count*Channel_Count-1:0]   rst_mask,
  output logic [Channel_Count-1:0]                chan_rst,
  output logic                                    busy,
  output logic                                    done,
  output logic [$clog2(Source_Count+1)-1:0]       cause
);

  localparam int unsigned CauseW = $clog2(Source_Count + 1);
  localparam int unsigned MaxDA  = (Delay_Cycles > Assert_Cycles) ? Delay_Cycles : Assert_Cycles;
  localparam int unsigned MaxCyc = (MaxDA > Stagger_Cycles) ? MaxDA : Stagger_Cycles;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam int unsigned PtrW   = (Channel_Count > 1) ? $clog2(Channel_Count) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_ASSERT, ST_RELEASE} state_t;

  state_t                     state;
  logic [Channel_Count-1:0]   active_mask;
  logic [Channel_Count-1:0]   pending_mask;
  logic [CauseW-1:0]          pending_cause;
  logic [PtrW-1:0]            chan_ptr;
  logic [CntW-1:0]            cnt;
  logic [Channel_Count-1:0]   rst_int;

  logic [Source_Count-1:0]    sync_q [Sync_Stages];
  logic [Source_Count-1:0]    sync_prev;
  logic [Source_Count-1:0]    req_edge;
  logic [Channel_Count-1:0]   out_pipe [Buffer_Stages];

  logic [Channel_Count-1:0]   eff_mask;
  logic [CauseW-1:0]          eff_cause;
  logic                       eff_any;
  logic [Channel_Count-1:0]   pend_mask_nxt;
  logic [CauseW-1:0]          pend_cause_nxt;
  logic [CntW-1:0]            slot_last;
  logic [PtrW-1:0]            next_ptr;

  // Synchroniser presets to 1 so a request held high through POR yields no edge
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      for (int i = 0; i < int'(Sync_Stages); i++) sync_q[i] <= '1;
      sync_prev <= '1;
      req_edge  <= '0;
    end else begin
      sync_q[0] <= rst_req;
      for (int i = 1; i < int'(Sync_Stages); i++) sync_q[i] <= sync_q[i-1];
      sync_prev <= sync_q[Sync_Stages-1];
      req_edge  <= sync_q[Sync_Stages-1] & ~sync_prev;
    end
  end

  // Effective sources: an edge from a source with an empty mask is ignored
  always_comb begin
    eff_mask  = '0;
    eff_cause = '0;
    eff_any   = 1'b0;
    for (int s = int'(Source_Count) - 1; s >= 0; s--) begin
      if (req_edge[s] && (|rst_mask[s*Channel_Count +: Channel_Count])) begin
        eff_mask  = eff_mask | rst_mask[s*Channel_Count +: Channel_Count];
        eff_cause = CauseW'(s);
        eff_any   = 1'b1;
      end
    end
  end

  always_comb begin
    pend_mask_nxt  = pending_mask | eff_mask;
    pend_cause_nxt = pending_cause;
    if (eff_any && ((pending_mask == '0) || (eff_cause < pending_cause)))
      pend_cause_nxt = eff_cause;
    slot_last = active_mask[chan_ptr] ? CntW'(Stagger_Cycles - 1) : '0;
    next_ptr  = chan_ptr + PtrW'(1);
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state         <= ST_ASSERT;
      active_mask   <= '1;
      pending_mask  <= '0;
      pending_cause <= '0;
      chan_ptr      <= '0;
      cnt           <= '0;
      rst_int       <= '1;
      busy          <= 1'b1;
      done          <= 1'b0;
      cause         <= CauseW'(Source_Count);
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (eff_any) begin
            active_mask <= eff_mask;
            cause       <= eff_cause;
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          active_mask <= active_mask | eff_mask;
          if (cnt == CntW'(Delay_Cycles - 1)) begin
            rst_int <= rst_int | active_mask | eff_mask;
            cnt     <= '0;
            state   <= ST_ASSERT;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        ST_ASSERT: begin
          pending_mask  <= pend_mask_nxt;
          pending_cause <= pend_cause_nxt;
          if (cnt == CntW'(Assert_Cycles - 1)) begin
            if (active_mask[0]) rst_int[0] <= 1'b0;
            chan_ptr <= '0;
            cnt      <= '0;
            state    <= ST_RELEASE;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        ST_RELEASE: begin
          pending_mask  <= pend_mask_nxt;
          pending_cause <= pend_cause_nxt;
          if (cnt == slot_last) begin
            cnt <= '0;
            if (chan_ptr == PtrW'(Channel_Count - 1)) begin
              // Requests seen up to and including this cycle chain straight into a new sequence
              done         <= 1'b1;
              pending_mask <= '0;
              if (pend_mask_nxt != '0) begin
                active_mask <= pend_mask_nxt;
                cause       <= pend_cause_nxt;
                state       <= ST_DELAY;
              end else begin
                active_mask <= '0;
                busy        <= 1'b0;
                state       <= ST_IDLE;
              end
            end else begin
              if (active_mask[next_ptr]) rst_int[next_ptr] <= 1'b0;
              chan_ptr <= next_ptr;
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output buffer chain, preset so every stage is in reset during POR
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      for (int i = 0; i < int'(Buffer_Stages); i++) out_pipe[i] <= '1;
    end else begin
      out_pipe[0] <= rst_int;
      for (int i = 1; i < int'(Buffer_Stages); i++) out_pipe[i] <= out_pipe[i-1];
    end
  end

  assign chan_rst = out_pipe[Buffer_Stages-1];

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; checks {chan_rst,busy,done,cause} per cycle.
module tb_reset_sequencer;

  logic       clk;
  logic       async_rst_n;
  logic [1:0] rst_req;
  logic [7:0] rst_mask;
  logic [3:0] chan_rst;
  logic       busy;
  logic       done;
  logic [1:0] cause;

  int total = 0;
  int bad   = 0;

  reset_sequencer dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .rst_req     (rst_req),
    .rst_mask    (rst_mask),
    .chan_rst    (chan_rst),
    .busy        (busy),
    .done        (done),
    .cause       (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [7:0] got, exp;
    async_rst_n = 1'b0;
    rst_req     = 2'b00;
    rst_mask    = 8'h00;
    repeat (3) @(negedge clk);
    got = {chan_rst, busy, done, cause};
    exp = {4'b1111, 1'b1, 1'b0, 2'd2};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", got, exp);
    end
    async_rst_n = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) exp[4+k] = (n < 12 + 16 * k);
      exp[3]   = (n < 72);
      exp[2]   = (n == 72);
      exp[1:0] = 2'd2;
      got = {chan_rst, busy, done, cause};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL por_seq n=%0d got=%b want=%b", n, got, exp);
      end
    end
  endtask

  task automatic test_single_source();
    logic [7:0] got, exp;
    rst_mask = 8'b0000_0101;
    rst_req  = 2'b01;
    for (int n = 1; n <= 1080; n++) begin
      @(posedge clk);
      @(negedge clk);
      exp      = '0;
      exp[4]   = (n >= 1032) && (n < 1040);
      exp[6]   = (n >= 1032) && (n < 1057);
      exp[3]   = (n >= 4) && (n < 1070);
      exp[2]   = (n == 1070);
      exp[1:0] = (n >= 4) ? 2'd0 : 2'd2;
      got = {chan_rst, busy, done, cause};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL single_src n=%0d got=%b want=%b", n, got, exp);
      end
      if (n == 10) rst_req = 2'b00;
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] got, exp;
    rst_mask = 8'b1000_0001;
    rst_req  = 2'b11;
    for (int n = 1; n <= 1080; n++) begin
      @(posedge clk);
      @(negedge clk);
      exp      = '0;
      exp[4]   = (n >= 1032) && (n < 1040);
      exp[7]   = (n >= 1032) && (n < 1058);
      exp[3]   = (n >= 4) && (n < 1070);
      exp[2]   = (n == 1070);
      exp[1:0] = 2'd0;
      got = {chan_rst, busy, done, cause};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL same_cycle n=%0d got=%b want=%b", n, got, exp);
      end
      if (n == 10) rst_req = 2'b00;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp;
    rst_mask = 8'b0010_0001;
    rst_req  = 2'b01;
    for (int n = 1; n <= 2120; n++) begin
      @(posedge clk);
      @(negedge clk);
      exp      = '0;
      exp[4]   = (n >= 1032) && (n < 1040);
      exp[5]   = (n >= 2083) && (n < 2092);
      exp[3]   = (n >= 4) && (n < 2106);
      exp[2]   = (n == 1055) || (n == 2106);
      exp[1:0] = (n >= 1055) ? 2'd1 : 2'd0;
      got = {chan_rst, busy, done, cause};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL back_to_back n=%0d got=%b want=%b", n, got, exp);
      end
      if (n == 10)   rst_req = 2'b00;
      if (n == 1040) rst_req = 2'b10;
      if (n == 1050) rst_req = 2'b00;
    end
  endtask

  task automatic test_empty_mask();
    logic [7:0] got, exp;
    rst_mask = 8'b0000_0001;
    for (int n = 1; n <= 60; n++) begin
      if ((n % 4) == 1) rst_req[1] = ~rst_req[1];
      @(posedge clk);
      @(negedge clk);
      exp = {4'b0000, 1'b0, 1'b0, 2'd1};
      got = {chan_rst, busy, done, cause};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL empty_mask n=%0d got=%b want=%b", n, got, exp);
      end
    end
    rst_req = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mid_delay_reset();
    logic [7:0] got, exp;
    rst_mask = 8'b0000_0001;
    rst_req  = 2'b01;
    repeat (100) @(negedge clk);
    got = {chan_rst, busy, done, cause};
    exp = {4'b0000, 1'b1, 1'b0, 2'd0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL in_delay got=%b want=%b", got, exp);
    end
    async_rst_n = 1'b0;
    #1;
    got = {chan_rst, busy, done, cause};
    exp = {4'b1111, 1'b1, 1'b0, 2'd2};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL abort_reset got=%b want=%b", got, exp);
    end
    repeat (2) @(negedge clk);
    async_rst_n = 1'b1;
    for (int n = 1; n <= 90; n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) exp[4+k] = (n < 12 + 16 * k);
      exp[3]   = (n < 72);
      exp[2]   = (n == 72);
      exp[1:0] = 2'd2;
      got = {chan_rst, busy, done, cause};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL abort_por n=%0d got=%b want=%b", n, got, exp);
      end
    end
    rst_req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_same_cycle();
    test_back_to_back();
    test_empty_mask();
    test_mid_delay_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
